// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcode constants, FSM state
// encoding and the command word layout {opcode, operand_a, operand_b}.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_NOP = 4'hF;

    localparam int unsigned CMD_W = 12;

    // Command word as presented on load_data: [11:8] opcode, [7:4] A, [3:0] B.
    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] operand_a;
        logic [3:0] operand_b;
    } cmd_t;

    // Stored entry: command plus its chain flag.
    typedef struct packed {
        logic chain;
        cmd_t cmd;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

    // Splits a raw load word into its command fields.
    function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
        return cmd_t'(raw);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command load channel of the ALU sequencer: a valid/ready write port.
// The master (host) drives the command, the slave (sequencer) returns ready.
interface alu_sequencer_if;
    logic        load_valid;
    logic [11:0] load_data;
    logic        load_chain;
    logic        load_ready;

    modport master (output load_valid, output load_data, output load_chain, input load_ready);
    modport slave  (input load_valid, input load_data, input load_chain, output load_ready);
endinterface

// File: rtl/alu_seq_store.sv
// Storage for the ALU sequencer: a command array with one write port and an
// asynchronous read port used by the issue logic, and a result array written
// during CAPTURE with a registered, count-gated readback port.
module alu_seq_store
    import alu_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_we_i,
    input  logic [AW-1:0]     cmd_waddr_i,
    input  entry_t            cmd_wdata_i,
    input  logic [AW-1:0]     cmd_raddr_i,
    output entry_t            cmd_rdata_o,
    input  logic              res_we_i,
    input  logic [AW-1:0]     res_waddr_i,
    input  logic [DATA_W-1:0] res_wdata_i,
    input  logic [4:0]        cmd_count_i,
    input  logic [3:0]        res_rd_addr_i,
    output logic [DATA_W-1:0] res_rd_data_o
);

    // Contents are valid-gated by the command count, so no reset is needed.
    entry_t            cmd_mem_q [DEPTH];
    logic [DATA_W-1:0] res_mem_q [DEPTH];
    logic [DATA_W-1:0] res_rd_data_q;

    assign cmd_rdata_o   = cmd_mem_q[cmd_raddr_i];
    assign res_rd_data_o = res_rd_data_q;

    // Command array write port.
    always_ff @(posedge clk) begin
        if (cmd_we_i) begin
            cmd_mem_q[cmd_waddr_i] <= cmd_wdata_i;
        end
    end

    // Result array write port, fed by the ALU during CAPTURE.
    always_ff @(posedge clk) begin
        if (res_we_i) begin
            res_mem_q[res_waddr_i] <= res_wdata_i;
        end
    end

    // Registered readback; addresses beyond the stored program read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_rd_data_q <= '0;
        end else if ({1'b0, res_rd_addr_i} < cmd_count_i) begin
            res_rd_data_q <= res_mem_q[res_rd_addr_i[AW-1:0]];
        end else begin
            res_rd_data_q <= '0;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer top. Commands are loaded over the alu_sequencer_if channel,
// then start replays them to an external combinational ALU, two cycles per
// command (ISSUE drives operands, CAPTURE stores the result).
// Optional feature macro ALU_SEQ_ACC_CHAIN_EN: a command loaded with its
// chain flag set takes operand A from the previously captured result (zero
// for the first command of a run). Without it the chain flag is ignored.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.slave    ld,
    input  logic              prog_clr,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        cmd_count,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        res_rd_addr,
    output logic [DATA_W-1:0] res_rd_data
);

    localparam int AW = $clog2(DEPTH);

    seq_state_e        state_q;
    logic [AW-1:0]     idx_q;
    logic [4:0]        cmd_count_q;
    logic              busy_q;
    logic              done_q;
    logic [3:0]        opcode_q;
    logic [DATA_W-1:0] operand_a_q;
    logic [DATA_W-1:0] operand_b_q;

    logic              load_ready_s;
    logic              clr_s;
    logic              load_acc_s;
    logic              last_s;
    logic [AW-1:0]     rd_addr_s;
    entry_t            rd_entry_s;
    entry_t            wr_entry_s;
    logic [3:0]        issue_op_s;
    logic [DATA_W-1:0] issue_a_s;
    logic [DATA_W-1:0] issue_b_s;
    logic              unused_chain_s;

    assign load_ready_s  = !busy_q && (cmd_count_q < 5'(DEPTH));
    assign clr_s         = prog_clr && (state_q == IDLE);
    assign load_acc_s    = ld.load_valid && load_ready_s && !clr_s;
    assign last_s        = (5'(idx_q) + 5'd1) >= cmd_count_q;
    assign ld.load_ready = load_ready_s;
    assign wr_entry_s    = '{chain: ld.load_chain, cmd: unpack_cmd(ld.load_data)};

    assign busy          = busy_q;
    assign done          = done_q;
    assign cmd_count     = cmd_count_q;
    assign alu_opcode    = opcode_q;
    assign alu_operand_a = operand_a_q;
    assign alu_operand_b = operand_b_q;

    // Look ahead to the entry issued at the next edge: entry 0 from IDLE, idx+1 from CAPTURE.
    always_comb begin
        if (state_q == CAPTURE) begin
            rd_addr_s = idx_q + AW'(1);
        end else begin
            rd_addr_s = idx_q;
        end
    end

    // Operands for the next issued command, with optional result chaining into A.
    always_comb begin
        issue_op_s     = rd_entry_s.cmd.opcode;
        issue_b_s      = DATA_W'(rd_entry_s.cmd.operand_b);
        unused_chain_s = 1'b0;
`ifdef ALU_SEQ_ACC_CHAIN_EN
        if (rd_entry_s.chain) begin
            if (state_q == CAPTURE) begin
                issue_a_s = alu_result;
            end else begin
                issue_a_s = '0;
            end
        end else begin
            issue_a_s = DATA_W'(rd_entry_s.cmd.operand_a);
        end
`else
        unused_chain_s = rd_entry_s.chain;
        issue_a_s      = DATA_W'(rd_entry_s.cmd.operand_a);
`endif
    end

    // Sequencer FSM with registered busy/done/ALU drive and the command counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cmd_count_q <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            opcode_q    <= OP_NOP;
            operand_a_q <= '0;
            operand_b_q <= '0;
        end else begin
            if (clr_s) begin
                cmd_count_q <= 5'd0;
            end else if (load_acc_s) begin
                cmd_count_q <= cmd_count_q + 5'd1;
            end else begin
                cmd_count_q <= cmd_count_q;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cmd_count_q != 5'd0) begin
                            state_q     <= ISSUE;
                            busy_q      <= 1'b1;
                            idx_q       <= '0;
                            opcode_q    <= issue_op_s;
                            operand_a_q <= issue_a_s;
                            operand_b_q <= issue_b_s;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (!last_s) begin
                        state_q     <= ISSUE;
                        idx_q       <= idx_q + AW'(1);
                        opcode_q    <= issue_op_s;
                        operand_a_q <= issue_a_s;
                        operand_b_q <= issue_b_s;
                    end else begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        idx_q       <= '0;
                        opcode_q    <= OP_NOP;
                        operand_a_q <= '0;
                        operand_b_q <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    idx_q       <= '0;
                    opcode_q    <= OP_NOP;
                    operand_a_q <= '0;
                    operand_b_q <= '0;
                end
            endcase
        end
    end

    alu_seq_store #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_store (
        .clk           (clk),
        .rst           (rst),
        .cmd_we_i      (load_acc_s),
        .cmd_waddr_i   (cmd_count_q[AW-1:0]),
        .cmd_wdata_i   (wr_entry_s),
        .cmd_raddr_i   (rd_addr_s),
        .cmd_rdata_o   (rd_entry_s),
        .res_we_i      (state_q == CAPTURE),
        .res_waddr_i   (idx_q),
        .res_wdata_i   (alu_result),
        .cmd_count_i   (cmd_count_q),
        .res_rd_addr_i (res_rd_addr),
        .res_rd_data_o (res_rd_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected issue tuples
// and done cycles into queues, a negedge monitor pops and compares them.
module tb_alu_sequencer;

    typedef struct {
        int         cyc;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } iss_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_clr = 1'b0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [4:0] cmd_count;
    logic [3:0] alu_opcode, alu_operand_a, alu_operand_b, alu_result;
    logic [3:0] res_rd_addr = 4'd0;
    logic [3:0] res_rd_data;

    alu_sequencer_if ld_if ();

    alu_sequencer #(.DEPTH(8), .DATA_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ld            (ld_if),
        .prog_clr      (prog_clr),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .cmd_count     (cmd_count),
        .alu_opcode    (alu_opcode),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_result    (alu_result),
        .res_rd_addr   (res_rd_addr),
        .res_rd_data   (res_rd_data)
    );

    always #5 clk = ~clk;

    // External combinational ALU.
    always_comb begin
        case (alu_opcode)
            4'h0:    alu_result = alu_operand_a + alu_operand_b;
            4'h1:    alu_result = alu_operand_a - alu_operand_b;
            4'h2:    alu_result = alu_operand_a & alu_operand_b;
            4'h3:    alu_result = alu_operand_a | alu_operand_b;
            default: alu_result = 4'h0;
        endcase
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    bit   mon_en = 1'b0;
    iss_t iss_q[$];
    int   done_q[$];

    logic [3:0] p_op[16];
    logic [3:0] p_a[16];
    logic [3:0] p_b[16];
    int         p_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: busy cycles alternate ISSUE/CAPTURE; idle cycles must show NOP.
    initial begin
        bit   phase = 1'b0;
        iss_t cur;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy) begin
                    if (!phase) begin
                        if (iss_q.size() == 0) begin
                            chk("issue_unexpected", 32'd1, 32'd0);
                        end else begin
                            cur = iss_q.pop_front();
                            chk("issue_cycle", cyc, cur.cyc);
                            chk("issue_ops", {alu_opcode, alu_operand_a, alu_operand_b},
                                {cur.op, cur.a, cur.b});
                        end
                    end else begin
                        chk("capture_hold", {alu_opcode, alu_operand_a, alu_operand_b},
                            {cur.op, cur.a, cur.b});
                    end
                    phase = !phase;
                end else begin
                    phase = 1'b0;
                    chk("idle_nop", {alu_opcode, alu_operand_a, alu_operand_b}, 32'hF00);
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("done_cycle", cyc, done_q.pop_front());
                    end
                    done_cnt++;
                end
            end
        end
    end

    task automatic load(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic chain, input logic [3:0] exp_a);
        @(negedge clk);
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = {op, a, b};
        ld_if.load_chain = chain;
        @(negedge clk);
        ld_if.load_valid = 1'b0;
        ld_if.load_chain = 1'b0;
        p_op[p_n] = op;
        p_a[p_n]  = exp_a;
        p_b[p_n]  = b;
        p_n++;
    endtask

    task automatic clear_prog();
        @(negedge clk);
        prog_clr = 1'b1;
        @(negedge clk);
        prog_clr = 1'b0;
        p_n = 0;
    endtask

    task automatic run_prog(input int n, input int hold);
        int c0, d0;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        d0 = done_cnt;
        for (int i = 0; i < n; i++) begin
            iss_q.push_back('{cyc: c0 + 1 + 2 * i, op: p_op[i], a: p_a[i], b: p_b[i]});
        end
        done_q.push_back((n > 0) ? c0 + 1 + 2 * n : c0 + 1);
        repeat (1 + hold) @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 60 && done_cnt == d0; k++) @(negedge clk);
        chk("run_done_seen", done_cnt - d0, 32'd1);
    endtask

    task automatic readback(input logic [3:0] addr, input logic [3:0] exp);
        @(negedge clk);
        res_rd_addr = addr;
        @(negedge clk);
        chk($sformatf("readback[%0d]", addr), res_rd_data, exp);
    endtask

    initial begin
        int c0;
        ld_if.load_valid = 1'b0;
        ld_if.load_data  = 12'h000;
        ld_if.load_chain = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", cmd_count, 5'd0);
        chk("rst_ready", ld_if.load_ready, 1'b1);
        chk("rst_opcode", alu_opcode, 4'hF);
        chk("rst_rd_data", res_rd_data, 4'h0);
        mon_en = 1'b1;

        // Single ADD 3,4 -> 7, done in cycle 3.
        load(4'h0, 4'h3, 4'h4, 1'b0, 4'h3);
        chk("count_1", cmd_count, 5'd1);
        run_prog(1, 0);
        readback(4'd0, 4'h7);

        // Mixed program including wrap, overflow, unknown opcode.
        clear_prog();
        chk("clr_count", cmd_count, 5'd0);
        load(4'h1, 4'h2, 4'h5, 1'b0, 4'h2);
        load(4'h0, 4'hF, 4'h1, 1'b0, 4'hF);
        load(4'h5, 4'h3, 4'h3, 1'b0, 4'h3);
        load(4'h2, 4'hC, 4'hA, 1'b0, 4'hC);
        load(4'h3, 4'h5, 4'hA, 1'b0, 4'h5);
        run_prog(5, 0);
        readback(4'd0, 4'hD);
        readback(4'd1, 4'h0);
        readback(4'd2, 4'h0);
        readback(4'd3, 4'h8);
        readback(4'd4, 4'hF);
        readback(4'd5, 4'h0);
        // Re-run the retained program.
        run_prog(5, 0);
        readback(4'd3, 4'h8);

        // prog_clr wins over a same-cycle load.
        @(negedge clk);
        prog_clr = 1'b1;
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 12'h011;
        @(negedge clk);
        prog_clr = 1'b0;
        ld_if.load_valid = 1'b0;
        p_n = 0;
        chk("clr_priority", cmd_count, 5'd0);
        readback(4'd0, 4'h0);

        // Fill to DEPTH, then a dropped 9th write.
        for (int i = 0; i < 8; i++) load(4'h0, 4'(i), 4'h1, 1'b0, 4'(i));
        chk("full_count", cmd_count, 5'd8);
        @(negedge clk);
        chk("full_ready", ld_if.load_ready, 1'b0);
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 12'h099;
        @(negedge clk);
        ld_if.load_valid = 1'b0;
        chk("full_count_hold", cmd_count, 5'd8);
        run_prog(8, 0);
        readback(4'd7, 4'h8);
        readback(4'd9, 4'h0);

        // Reset during CAPTURE of command 3 aborts without done.
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            iss_q.push_back('{cyc: c0 + 1 + 2 * i, op: p_op[i], a: p_a[i], b: p_b[i]});
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_run", busy, 1'b1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_opcode", alu_opcode, 4'hF);
        chk("abort_count", cmd_count, 5'd0);
        chk("abort_done", done, 1'b0);
        repeat (4) @(negedge clk);
        p_n = 0;

        // Chained ADD; start held while busy must be ignored.
        load(4'h0, 4'h1, 4'h2, 1'b0, 4'h1);
`ifdef ALU_SEQ_ACC_CHAIN_EN
        load(4'h0, 4'h6, 4'h5, 1'b1, 4'h3);
`else
        load(4'h0, 4'h6, 4'h5, 1'b1, 4'h6);
`endif
        run_prog(2, 2);
        readback(4'd0, 4'h3);
`ifdef ALU_SEQ_ACC_CHAIN_EN
        readback(4'd1, 4'h8);
`else
        readback(4'd1, 4'hB);
`endif

        // Empty program: done in cycle 1, no busy.
        clear_prog();
        run_prog(0, 0);

        repeat (4) @(negedge clk);
        chk("issue_q_empty", iss_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
